// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encodings and width limits shared by the serial adder.
package serial_adder_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational full adder from two half adders and an OR.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic w_h1s, w_h1c, w_h2c;
  assign w_h1s = a ^ b;
  assign w_h1c = a & b;
  assign s     = w_h1s ^ cin;
  assign w_h2c = w_h1s & cin;
  assign co    = w_h1c | w_h2c;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one bit per clock LSB first, done pulse on completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder WIDTH out of range");
  end
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_co;
  serial_fa_cell u_fa (.a(r_a[0]), .b(r_b[0]), .cin(r_c), .s(w_s), .co(w_co));
  assign busy = r_state == S_RUN;
  assign done = r_state == S_DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (r_state != S_RUN) begin
      r_state <= start ? S_RUN : S_IDLE;
      if (start) begin
        r_a   <= a;
        r_b   <= b ^ {WIDTH{sub}};
        r_c   <= sub;
        r_cnt <= '0;
      end
    end else begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= {w_s, r_res[WIDTH-1:1]};
      r_c   <= w_co;
      // r_c still holds the carry into the MSB on the last-bit edge
      if (r_cnt == LAST) begin
        sum      <= {w_s, r_res[WIDTH-1:1]};
        cout     <= w_co;
        overflow <= r_c ^ w_co;
        r_state  <= S_DONE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial add/subtract unit for the ALU datapath.
- Accepts two WIDTH-bit operands on a start strobe.
- Processes one bit per clock, LSB first, through a single full-adder cell and a carry flop.
- Presents sum, carry-out and signed overflow with a one-cycle done pulse.
- Sits directly downstream of the operand source and drives the adder cell each cycle; this is the area-lean alternative to the parallel adder path.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk       input   1      rising-edge clock
rst_n     input   1      asynchronous active-low reset
start     input   1      request; sampled on rising edge when not busy
sub       input   1      0 = A+B, 1 = A-B; sampled with start
a         input   WIDTH  operand A; sampled with start
b         input   WIDTH  operand B; sampled with start
busy      output  1      high while state = RUN
done      output  1      one-cycle pulse; result valid
sum       output  WIDTH  result register
cout      output  1      carry out; for sub, 1 = no borrow (A >= B unsigned)
overflow  output  1      two's-complement signed overflow

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; busy, done, sum, cout, overflow all 0.
  - Shift registers, carry flop and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start=1 → RUN. At that edge:
    - opA_sr = a
    - opB_sr = b XOR {WIDTH{sub}}
    - carry = sub
    - cnt = 0
  - RUN, each edge:
    - bit = opA_sr[0] ^ opB_sr[0] ^ carry; carry ← majority(opA_sr[0], opB_sr[0], carry).
    - opA_sr and opB_sr shift right.
    - res_sr shifts right with bit entering at MSB.
    - cnt++.
  - RUN, edge where cnt = WIDTH-1 (last bit):
    - sum ← final res_sr value, with the MSB bit included.
    - cout ← new carry.
    - overflow ← carry-into-MSB XOR new carry.
    - state → DONE.
  - DONE: done = 1 for exactly this cycle, busy = 0, then → IDLE unless start = 1.
- Latency: start sampled at edge k → done high in the cycle following edge k+WIDTH. Next start accepted in that same DONE cycle, so back-to-back throughput is one op per WIDTH+1 cycles.
- Output hold: sum/cout/overflow are updated only at the last-bit edge and hold their value through any following RUN until the next completion.
- start during RUN: ignored; no queuing; a, b, sub not sampled.
- Counter width: clog2(WIDTH); no wrap past WIDTH-1.
- Reset mid-RUN: operation aborted immediately; outputs return to 0; no done pulse.
- sub=1 with b=0: result = a, cout = 1.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the WIDTH range limits
- One natural sub-module: serial_fa_cell. Combinational full adder (a, b, cin → s, co) built from two half adders plus an OR; instanced once.

Test Plan:
1. WIDTH=8, a=0x35, b=0x4A, sub=0 → sum=0x7F, cout=0, overflow=0; done exactly one cycle, in the cycle after edge k+8; busy high for 8 cycles.
2. a=0xFF, b=0x01, sub=0 → sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, overflow=1.
3. sub=1: a=0x10, b=0x20 → sum=0xF0, cout=0, overflow=0. Then a=0x80, b=0x01 → sum=0x7F, cout=1, overflow=1.
4. Start 0x35+0x4A, then pulse start with a=0xFF, b=0xFF at cycle 3 of RUN → ignored; result still 0x7F; exactly one done pulse.
5. Assert rst_n=0 mid-RUN at cycle 4 → all outputs 0 asynchronously; after release, no done until a new start; a fresh 0x01+0x02 gives 0x03.
6. Hold start high in the DONE cycle with a=0x0F, b=0x01 → second RUN begins with no IDLE gap; sum=0x10 nine cycles later; done pulses twice, 9 cycles apart.
